// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with lockable grants and registered read return.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority to requester 0.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module dmem_arbiter #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [`WORD_LEN-1:0] a0,
  input  logic [`WORD_LEN-1:0] a1,
  input  logic [`WORD_LEN-1:0] wd0,
  input  logic [`WORD_LEN-1:0] wd1,
  input  logic                 lock0,
  input  logic                 lock1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic [`WORD_LEN-1:0] rdata,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic                 mem_we,
  output logic [`WORD_LEN-1:0] mem_a,
  output logic [`WORD_LEN-1:0] mem_wd,
  input  logic [`WORD_LEN-1:0] mem_rd
);

  localparam int unsigned W  = `WORD_LEN;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          force_q, force_d;
  logic          force_id_q, force_id_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic          last_q, last_d;
`endif
  logic [W-1:0]  mem_a_q, mem_a_d;
  logic [W-1:0]  mem_wd_q, mem_wd_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic          win;
  logic          any_gnt;
  logic          win_we;
  logic          win_lock;
  logic [CW-1:0] base_cnt;
  logic [CW-1:0] new_cnt;

  // Arbitration, lock tracking and memory-port steering.
  always_comb begin
    state_d    = IDLE;
    cnt_d      = '0;
    force_d    = force_q;
    force_id_d = force_id_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    mem_a_d    = mem_a_q;
    mem_wd_d   = mem_wd_q;
    rdata_d    = rdata_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_we     = 1'b0;
    win        = 1'b0;
    any_gnt    = 1'b0;
    win_we     = 1'b0;
    win_lock   = 1'b0;
    base_cnt   = '0;
    new_cnt    = '0;

    // An owner keeps the port while it requests; otherwise arbitrate as if idle.
    if (state_q == OWN0 && req0) begin
      any_gnt  = 1'b1;
      win      = 1'b0;
      base_cnt = cnt_q;
    end else if (state_q == OWN1 && req1) begin
      any_gnt  = 1'b1;
      win      = 1'b1;
      base_cnt = cnt_q;
    end else if (req0 && req1) begin
      any_gnt = 1'b1;
      if (force_q) begin
        win = ~force_id_q;
      end else begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        win = ~last_q;
`else
        win = 1'b0;
`endif
      end
    end else if (req0) begin
      any_gnt = 1'b1;
      win     = 1'b0;
    end else if (req1) begin
      any_gnt = 1'b1;
      win     = 1'b1;
    end

    if (rst) any_gnt = 1'b0;

    if (any_gnt) begin
      win_we    = win ? we1 : we0;
      win_lock  = win ? lock1 : lock0;
      gnt0      = ~win;
      gnt1      = win;
      mem_we    = win_we;
      mem_a_d   = win ? a1 : a0;
      mem_wd_d  = win ? wd1 : wd0;
      rvalid0_d = ~win & ~win_we;
      rvalid1_d = win & ~win_we;
      if (!win_we) rdata_d = mem_rd;
      force_d   = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_d    = win;
`endif
      new_cnt   = base_cnt + CW'(1);
      // Hitting the lock limit drops to IDLE and hands the next tie to the other side.
      if (win_lock) begin
        if (new_cnt >= CW'(MAX_LOCK)) begin
          force_d    = 1'b1;
          force_id_d = win;
        end else begin
          state_d = win ? OWN1 : OWN0;
          cnt_d   = new_cnt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      force_q    <= 1'b0;
      force_id_q <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
      rdata_q    <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      force_q    <= force_d;
      force_id_q <= force_id_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
      mem_a_q    <= mem_a_d;
      mem_wd_q   <= mem_wd_d;
      rdata_q    <= rdata_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign mem_a   = mem_a_d;
  assign mem_wd  = mem_wd_d;
  assign rdata   = rdata_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected read returns, a monitor checks them.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_dmem_arbiter;

  localparam int unsigned W = `WORD_LEN;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic [31:0]  due;
  } exp_t;

  logic         clk, rst;
  logic         req0, req1, we0, we1, lock0, lock1;
  logic [W-1:0] a0, a1, wd0, wd1;
  logic         gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [W-1:0] rdata, mem_a, mem_wd, mem_rd;

  logic [W-1:0] mem [0:15];
  exp_t         sb[$];
  exp_t         mon_e;
  logic [31:0]  cyc_n;
  int           total;
  int           bad;

  dmem_arbiter #(.MAX_LOCK(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge.
  assign mem_rd = mem[mem_a[5:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[5:2]] <= mem_wd;

  initial cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Each expected read return is due exactly one cycle after acceptance.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      mon_e = sb.pop_front();
      check("rvalid_pair", W'({rvalid1, rvalid0}), W'({mon_e.id, ~mon_e.id}));
      check("rdata", rdata, mon_e.data);
    end else if (rvalid0 || rvalid1) begin
      total++;
      bad++;
      $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b expected none", rvalid0, rvalid1);
    end
  end

  task automatic cyc(input logic rs,
                     input logic r0, input logic w0_, input logic [W-1:0] ad0, input logic [W-1:0] dt0, input logic l0,
                     input logic r1, input logic w1_, input logic [W-1:0] ad1, input logic [W-1:0] dt1, input logic l1,
                     input logic eg0, input logic eg1, input logic [W-1:0] erd, input string nm);
    exp_t e;
    rst = rs; req0 = r0; we0 = w0_; a0 = ad0; wd0 = dt0; lock0 = l0;
    req1 = r1; we1 = w1_; a1 = ad1; wd1 = dt1; lock1 = l1;
    @(negedge clk);
    check({nm, " gnt0"}, W'(gnt0), W'(eg0));
    check({nm, " gnt1"}, W'(gnt1), W'(eg1));
    check({nm, " mem_we"}, W'(mem_we), W'((eg0 & w0_) | (eg1 & w1_)));
    if ((eg0 && !w0_) || (eg1 && !w1_)) begin
      e.id   = eg1;
      e.data = erd;
      e.due  = cyc_n + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rs, input string nm);
    cyc(rs, L, L, 0, 0, L, L, L, 0, 0, L, L, L, 0, nm);
  endtask

  initial begin
    logic g1;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    a0 = '0; a1 = '0; wd0 = '0; wd1 = '0; lock0 = 1'b0; lock1 = 1'b0;
    @(posedge clk); #1;

    // Reset state
    idle(H, "rst");
    idle(H, "rst");
    check("rst rdata", rdata, 0);
    check("rst rvalid", W'({rvalid1, rvalid0}), 0);
    check("rst mem_a", mem_a, 0);
    check("rst mem_wd", mem_wd, 0);

    // Write then read same address
    cyc(L, H, H, 4, 32'hdeadbeef, L, L, L, 0, 0, L, H, L, 0, "wr4");
    cyc(L, H, L, 4, 0, L, L, L, 0, 0, L, H, L, 32'hdeadbeef, "rd4");
    cyc(L, H, H, 0, 32'h11111111, L, L, L, 0, 0, L, H, L, 0, "wr0");
    cyc(L, L, L, 0, 0, L, H, H, 8, 32'h22222222, L, L, H, 0, "wr8");

    // Interleaved read burst
    cyc(L, H, L, 0, 0, L, L, L, 0, 0, L, H, L, 32'h11111111, "ilv0");
    cyc(L, L, L, 0, 0, L, H, L, 4, 0, L, L, H, 32'hdeadbeef, "ilv1");
    cyc(L, H, L, 8, 0, L, L, L, 0, 0, L, H, L, 32'h22222222, "ilv2");
    cyc(L, L, L, 0, 0, L, H, L, 0, 0, L, L, H, 32'h11111111, "ilv3");
    cyc(L, H, L, 4, 0, L, L, L, 0, 0, L, H, L, 32'hdeadbeef, "ilv4");
    idle(L, "gap");

    // Simultaneous unlocked reads
    idle(H, "rst2");
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      g1 = 1'(i % 2);
`else
      g1 = 1'b0;
`endif
      cyc(L, H, L, 0, 0, L, H, L, 8, 0, L, ~g1, g1, g1 ? 32'h22222222 : 32'h11111111, "tie");
    end
    idle(L, "gap");

    // Lock limit release
    idle(H, "rst3");
    cyc(L, L, L, 0, 0, L, H, L, 4, 0, H, L, H, 32'hdeadbeef, "lock1st");
    for (int i = 0; i < 7; i++)
      cyc(L, H, L, 0, 0, L, H, L, 4, 0, H, L, H, 32'hdeadbeef, "lockhold");
    cyc(L, H, L, 0, 0, L, H, L, 4, 0, H, H, L, 32'h11111111, "lockrel");
    idle(L, "gap");

    // Reset during ownership
    idle(H, "rst4");
    cyc(L, L, L, 0, 0, L, H, L, 8, 0, H, L, H, 32'h22222222, "own1");
    cyc(H, H, L, 4, 0, L, H, L, 8, 0, H, L, L, 0, "midrst");
    check("midrst rdata", rdata, 0);
    check("midrst rvalid1", W'(rvalid1), 0);
    cyc(L, H, L, 4, 0, L, H, L, 8, 0, H, H, L, 32'hdeadbeef, "postrst");

    // Idle hold and memory integrity
    for (int i = 0; i < 4; i++) idle(L, "idle");
    check("hold mem_a", mem_a, 4);
    check("hold mem_wd", mem_wd, 0);
    cyc(L, H, L, 4, 0, L, L, L, 0, 0, L, H, L, 32'hdeadbeef, "rdfinal");
    check("mem4", mem[1], 32'hdeadbeef);
    for (int i = 0; i < 3; i++) idle(L, "drain");
    check("sb_empty", W'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
